// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial add/subtract sequencer: FSM state encoding
// and the index-width helper used to size slice counters and part-select bases.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus between the instruction sequencer
// (master) and the serial add/subtract sequencer (slave).
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int SLICE   = 8,
    parameter int NSLICES = 4
);
    localparam int W = SLICE * NSLICES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_add_ctrl_addern.sv
// Narrow ripple adder slice reused by the serial sequencer once per cycle.
module addern #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide add/subtract built from one SLICE-bit adder reused over NSLICES cycles,
// LSB slice first, with the inter-slice carry held in a flip-flop.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int SLICE   = 8,
    parameter int NSLICES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int W  = SLICE * NSLICES;
    localparam int KW = idx_w(NSLICES);
    localparam int AW = idx_w(W);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [KW-1:0]    k;
    logic             carry;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             accept;
    logic             last;
    logic [AW-1:0]    base;
    logic [SLICE-1:0] s_sum;
    logic             s_cout;
    logic             busy_c;
    logic             done_c;

    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (state == ST_RUN) && (k == K_LAST);
    assign base   = AW'(k) * AW'(SLICE);

    addern #(.SLICE(SLICE)) u_addern (
        .a    (opa[base +: SLICE]),
        .b    (opb[base +: SLICE]),
        .cin  (carry),
        .s    (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (k == K_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == ST_RUN);
        done_c = (state == ST_DONE);
    end

    // Subtract stores ~b; cin is an active-low borrow there, so it feeds the carry unchanged.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa <= bus.a;
            opb <= bus.sub ? ~bus.b : bus.b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            carry <= bus.cin;
            k     <= '0;
            sum_q <= '0;
        end else if (state == ST_RUN) begin
            sum_q[base +: SLICE] <= s_sum;
            carry                <= s_cout;
            if (last) begin
                cout_q <= s_cout;
                ovf_q  <= (opa[W-1] == opb[W-1]) && (s_sum[SLICE-1] != opa[W-1]);
                k      <= '0;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed corner cases and seeded random
// back-to-back operations compared against an arithmetic reference model.
module tb_serial_add_ctrl;
    import serial_add_ctrl_pkg::*;

    localparam int SLICE = 8;
    localparam int NSL   = 4;
    localparam int W     = SLICE * NSL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_cout = 1'b0;
    logic prev_ovf  = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.SLICE(SLICE), .NSLICES(NSL)) bus ();

    serial_add_ctrl #(.SLICE(SLICE), .NSLICES(NSL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic; returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        longint ua, ub, sa, sb, ur, sr, c;
        logic   co, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = longint'(cin);
        if (!sub) begin
            ur = ua + ub + c;
            sr = sa + sb + c;
            co = (ur >= 64'sd4294967296);
        end else begin
            ur = ua - ub - (1 - c);
            sr = sa - sb - (1 - c);
            co = (ur >= 0);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, co, ur[W-1:0]};
    endfunction

    // Called at a negedge with the DUT idle or done; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.cin   = 1'($urandom);
        bus.sub   = 1'($urandom);
        check("accept_busy", 64'(bus.busy), 64'd1);
        check("accept_sum_clear", 64'(bus.sum), 64'd0);
        check("accept_cout_hold", 64'(bus.cout), 64'(prev_cout));
        check("accept_ovf_hold", 64'(bus.ovf), 64'(prev_ovf));
    endtask

    // Waits for done (bounded) and checks latency and result; ends on the done negedge.
    task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input int exp_lat);
        logic [W+1:0] exp;
        int           cyc;
        logic         got;
        exp = model(a, b, cin, sub);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 4 * NSL + 8) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            got = bus.done;
        end
        if (!got) begin
            check({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
            check({tag, "_sum"}, 64'(bus.sum), 64'(exp[W-1:0]));
            check({tag, "_cout"}, 64'(bus.cout), 64'(exp[W]));
            check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp[W+1]));
            check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
            prev_cout = exp[W];
            prev_ovf  = exp[W+1];
        end
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check(tag, 64'(n), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] da [7];
        logic [W-1:0] db [7];
        logic         dc [7];
        logic         ds [7];
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        da = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000,
               32'h8000_0000, 32'h0000_0000};
        db = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001,
               32'h8000_0000, 32'h0000_0000};
        dc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ds = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        void'($urandom(32'h5EED_0181));
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted mid-operation, between clock edges.
        issue(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_sum", 64'(bus.sum), 64'd0);
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_done("midrst_no_done", 8);

        // Directed corner cases, back-to-back.
        issue(da[0], db[0], dc[0], ds[0]);
        for (int i = 0; i < 7; i++) begin
            wait_result($sformatf("dir%0d", i), da[i], db[i], dc[i], ds[i], NSL);
            if (i < 6) issue(da[i+1], db[i+1], dc[i+1], ds[i+1]);
        end
        count_done("dir_idle_no_done", 3);

        // start re-asserted while running must be ignored.
        issue(32'd1, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_result("ignore_start", 32'd1, 32'd2, 1'b0, 1'b0, 2);
        count_done("ignore_single_done", 6);
        check("sum_held_idle", 64'(bus.sum), 64'd3);

        // start accepted in the DONE cycle.
        issue(32'd1, 32'd2, 1'b0, 1'b0);
        wait_result("b2b_first", 32'd1, 32'd2, 1'b0, 1'b0, NSL);
        issue(32'd4, 32'd4, 1'b0, 1'b0);
        wait_result("b2b_second", 32'd4, 32'd4, 1'b0, 1'b0, NSL);
        @(negedge clk);

        // Seeded random operations, back-to-back.
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom);
        rs = 1'($urandom);
        issue(ra, rb, rc, rs);
        for (int i = 0; i < 181; i++) begin
            logic [W-1:0] na, nb;
            logic         nc, ns;
            na = $urandom;
            nb = $urandom;
            nc = 1'($urandom);
            ns = 1'($urandom);
            wait_result($sformatf("rnd%0d", i), ra, rb, rc, rs, NSL);
            if (i < 180) begin
                issue(na, nb, nc, ns);
                ra = na;
                rb = nb;
                rc = nc;
                rs = ns;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
